// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the fully associative branch target buffer.
package btb_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int ENTRIES      = 8;
  localparam int CTR_BITS     = 2;
  localparam int TAG_WIDTH    = PC_WIDTH - 2;
  localparam int CTR_MAX_BITS = 8;

  localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [PC_WIDTH-1:0]   target;
    logic [CTR_BITS-1:0]   ctr;
  } btb_entry_t;

  // Counters narrower than CTR_MAX_BITS are zero-extended by the caller with their own ceiling.
  function automatic logic [CTR_MAX_BITS-1:0] sat_update(
    input logic [CTR_MAX_BITS-1:0] ctr,
    input logic [CTR_MAX_BITS-1:0] ctr_max,
    input logic                    taken
  );
    if (taken) return (ctr == ctr_max) ? ctr : ctr + CTR_MAX_BITS'(1);
    return (ctr == '0) ? ctr : ctr - CTR_MAX_BITS'(1);
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// One BTB entry's saturating direction counter: init to weakly taken, or step up/down.
import btb_pkg::*;

module btb_sat_ctr #(
  parameter int width = CTR_BITS
) (
  input  logic clk,
  input  logic init_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic taken_o
);

  localparam logic [width-1:0] CTR_MAX  = '1;
  localparam logic [width-1:0] CTR_INIT = width'(1) << (width - 1);

  logic [width-1:0] ctr_q;
  logic [width-1:0] ctr_d;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    ctr_d = ctr_q;
    if (init_i) begin
      ctr_d = CTR_INIT;
    end else if (inc_i || dec_i) begin
      ctr_d = width'(sat_update(CTR_MAX_BITS'(ctr_q), CTR_MAX_BITS'(CTR_MAX), inc_i));
    end
  end

  // NOTE: counter contents are meaningless until the entry is allocated, so this storage has
  // no reset; the sequential assignment is non-blocking like all state.
  always_ff @(posedge clk) begin
    ctr_q <= ctr_d;
  end

  assign taken_o = ctr_q[width-1];

endmodule

// File: rtl/btb_assoc.sv
// Fully associative BTB: combinational lookup on the fetch PC, registered update from execute
// with invalid-first allocation and round-robin eviction.
import btb_pkg::*;

module btb_assoc #(
  parameter int pc_width = PC_WIDTH,
  parameter int entries  = ENTRIES,
  parameter int ctr_bits = CTR_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [pc_width-1:0]         lookup_pc_i,
  output logic                        hit_o,
  output logic                        predict_taken_o,
  output logic [pc_width-1:0]         predict_target_o,
  input  logic                        update_valid_i,
  input  logic [pc_width-1:0]         update_pc_i,
  input  logic                        update_taken_i,
  input  logic [pc_width-1:0]         update_target_i,
  input  logic                        flush_i,
  output logic [$clog2(entries):0]    occupancy_o
);

  localparam int IDX_W = $clog2(entries);
  localparam int TAG_W = pc_width - 2;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [pc_width-1:0] target;
  } slot_t;

  slot_t              slot_q [entries];
  logic [entries-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W:0]     occ_q, occ_d;

  logic [entries-1:0]  lk_match, upd_match, ctr_taken;
  logic [entries-1:0]  alloc_vec, inc_vec, dec_vec;
  logic [pc_width-1:0] lk_target;
  logic                upd_en, upd_hit, alloc, free_found;
  logic [IDX_W-1:0]    free_idx, victim_idx;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

  // Tags are unique among valid entries, so OR-ing the masked targets is a one-hot mux.
  always_comb begin
    lk_target = '0;
    lk_match  = '0;
    upd_match = '0;
    for (int i = 0; i < entries; i++) begin
      lk_match[i]  = valid_q[i] && (slot_q[i].tag == lookup_pc_i[pc_width-1:2]);
      upd_match[i] = valid_q[i] && (slot_q[i].tag == update_pc_i[pc_width-1:2]);
      if (lk_match[i]) lk_target = lk_target | slot_q[i].target;
    end
  end

  assign hit_o            = |lk_match;
  assign predict_taken_o  = |(lk_match & ctr_taken);
  assign predict_target_o = lk_target;

  // Descending scan leaves the lowest-index free slot as the final winner.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = entries - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign upd_en     = update_valid_i && !flush_i;
  assign upd_hit    = |upd_match;
  assign alloc      = upd_en && !upd_hit && update_taken_i;
  assign victim_idx = free_found ? free_idx : ptr_q;

  always_comb begin
    for (int i = 0; i < entries; i++) begin
      alloc_vec[i] = alloc && (victim_idx == IDX_W'(i));
      inc_vec[i]   = upd_en && upd_match[i] && update_taken_i;
      dec_vec[i]   = upd_en && upd_match[i] && !update_taken_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    occ_d   = occ_q;
    if (flush_i) begin
      valid_d = '0;
      ptr_d   = '0;
      occ_d   = '0;
    end else if (alloc) begin
      valid_d = valid_q | alloc_vec;
      if (free_found) occ_d = occ_q + (IDX_W + 1)'(1);
      else            ptr_d = ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < entries; i++) begin
      if (alloc_vec[i]) begin
        slot_q[i].tag    <= update_pc_i[pc_width-1:2];
        slot_q[i].target <= update_target_i;
      end else if (inc_vec[i]) begin
        slot_q[i].target <= update_target_i;
      end
    end
  end

  for (genvar g = 0; g < entries; g++) begin : g_ctr
    btb_sat_ctr #(.width(ctr_bits)) u_ctr (
      .clk     (clk),
      .init_i  (alloc_vec[g]),
      .inc_i   (inc_vec[g]),
      .dec_i   (dec_vec[g]),
      .taken_o (ctr_taken[g])
    );
  end

  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (default parameters: 32-bit PC, 8 entries, 2-bit counters).
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        flush = 1'b0;
  logic [3:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  btb_assoc dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc_i      (lookup_pc),
    .hit_o            (hit),
    .predict_taken_o  (predict_taken),
    .predict_target_o (predict_target),
    .update_valid_i   (update_valid),
    .update_pc_i      (update_pc),
    .update_taken_i   (update_taken),
    .update_target_i  (update_target),
    .flush_i          (flush),
    .occupancy_o      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tgt;
    @(posedge clk);
    #1;
    update_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    look(32'h100);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", hit); end
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", predict_taken); end
    n_vec++; if (predict_target !== 32'h0) begin n_err++; $display("FAIL reset_target: got %h want 0", predict_target); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alloc;
    upd(32'h100, 1'b1, 32'h200);
    look(32'h100);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit: got %b want 1", hit); end
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", predict_taken); end
    n_vec++; if (predict_target !== 32'h200) begin n_err++; $display("FAIL alloc_target: got %h want 200", predict_target); end
    n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL alloc_occ: got %0d want 1", occupancy); end
    look(32'h102);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL low_bits_ignored: got %b want 1", hit); end
    look(32'h104);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL neighbour_miss: got %b want 0", hit); end
  endtask

  task automatic test_counter;
    // 2 -> 1 -> 0
    upd(32'h100, 1'b0, 32'h0); look(32'h100);
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL ctr1_taken: got %b want 0", predict_taken); end
    upd(32'h100, 1'b0, 32'h0); look(32'h100);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL ctr0_hit: got %b want 1", hit); end
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL ctr0_taken: got %b want 0", predict_taken); end
    n_vec++; if (predict_target !== 32'h200) begin n_err++; $display("FAIL nt_keeps_target: got %h want 200", predict_target); end
    // 0 -> 0 (floor), then 0 -> 1 still not-taken
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200); look(32'h100);
    n_vec++; if (predict_taken !== 1'b0) begin n_err++; $display("FAIL floor_sat_taken: got %b want 0", predict_taken); end
    // 1 -> 2 -> 3 -> 3 (ceiling); one not-taken then lands on 2, still taken
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h280); look(32'h100);
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL ctr3_taken: got %b want 1", predict_taken); end
    n_vec++; if (predict_target !== 32'h280) begin n_err++; $display("FAIL taken_retarget: got %h want 280", predict_target); end
    upd(32'h100, 1'b0, 32'h0); look(32'h100);
    n_vec++; if (predict_taken !== 1'b1) begin n_err++; $display("FAIL ceil_sat_taken: got %b want 1", predict_taken); end
    n_vec++; if (occupancy !== 4'd1) begin n_err++; $display("FAIL hit_no_alloc_occ: got %0d want 1", occupancy); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    flush = 1'b1; update_valid = 1'b1;
    update_pc = 32'h500; update_taken = 1'b1; update_target = 32'h600;
    @(posedge clk); #1;
    flush = 1'b0; update_valid = 1'b0;
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    look(32'h100);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL flush_old_entry: got %b want 0", hit); end
    look(32'h500);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL flush_drops_update: got %b want 0", hit); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) upd(32'(i * 4), 1'b1, 32'h1000 + 32'(i * 4));
    n_vec++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL fill_occ: got %0d want 8", occupancy); end
    look(32'h1C);
    n_vec++; if (predict_target !== 32'h101C) begin n_err++; $display("FAIL fill_last_target: got %h want 101c", predict_target); end
    upd(32'h600, 1'b0, 32'h0); look(32'h600);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL nt_miss_no_alloc: got %b want 0", hit); end
    look(32'h00);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL nt_miss_no_evict: got %b want 1", hit); end
    upd(32'h40, 1'b1, 32'h2040);
    look(32'h00);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL evict0_old: got %b want 0", hit); end
    look(32'h40);
    n_vec++; if (hit !== 1'b1 || predict_target !== 32'h2040) begin n_err++; $display("FAIL evict0_new: got hit=%b tgt=%h want hit=1 tgt=2040", hit, predict_target); end
    n_vec++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL evict_occ: got %0d want 8", occupancy); end
    upd(32'h44, 1'b1, 32'h2044);
    look(32'h04);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL evict1_old: got %b want 0", hit); end
    look(32'h08);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL evict1_neighbour: got %b want 1", hit); end
    look(32'h44);
    n_vec++; if (hit !== 1'b1 || predict_target !== 32'h2044) begin n_err++; $display("FAIL evict1_new: got hit=%b tgt=%h want hit=1 tgt=2044", hit, predict_target); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    lookup_pc = 32'h300;
    update_valid = 1'b1; update_pc = 32'h300; update_taken = 1'b1; update_target = 32'h400;
    #1;
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL same_cycle_old: got %b want 0", hit); end
    @(posedge clk); #1;
    update_valid = 1'b0;
    n_vec++; if (hit !== 1'b1 || predict_target !== 32'h400) begin n_err++; $display("FAIL same_cycle_next: got hit=%b tgt=%h want hit=1 tgt=400", hit, predict_target); end
    look(32'h08);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL evict2_old: got %b want 0", hit); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    lookup_pc = 32'h300;
    update_valid = 1'b1; update_pc = 32'h700; update_taken = 1'b1; update_target = 32'h800;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (hit !== 1'b0 || predict_taken !== 1'b0 || predict_target !== 32'h0) begin
      n_err++; $display("FAIL async_reset_outputs: got hit=%b tk=%b tgt=%h want all 0", hit, predict_taken, predict_target);
    end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL async_reset_occ: got %0d want 0", occupancy); end
    @(negedge clk);
    rst = 1'b0; update_valid = 1'b0;
    look(32'h700);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_drops_update: got %b want 0", hit); end
    upd(32'h900, 1'b1, 32'h904); look(32'h900);
    n_vec++; if (hit !== 1'b1 || occupancy !== 4'd1) begin n_err++; $display("FAIL post_reset_alloc: got hit=%b occ=%0d want hit=1 occ=1", hit, occupancy); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_flush();
    test_wrap();
    test_same_cycle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
